// File: rtl/output_writeback_unit.sv
// Output writeback unit: picks a write source, applies circular frame addressing,
// registers the activation-memory write and mirrors it into an external output queue.
module output_writeback_unit #(
    parameter int N_DIM_ARRAY    = 8,
    parameter int ACT_DATA_WIDTH = 8,
    parameter int ADDR_SIZE      = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  sel_nl,
    input  logic                                  wr_en_cu,
    input  logic [ADDR_SIZE-1:0]                  wr_addr_cu,
    input  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] wr_data_cu,
    input  logic                                  wr_en_nl,
    input  logic [ADDR_SIZE-1:0]                  wr_addr_nl,
    input  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] wr_data_nl,
    input  logic                                  tcn_active,
    input  logic [ADDR_SIZE-1:0]                  tcn_block_size,
    input  logic [ADDR_SIZE-1:0]                  tcn_total_blocks,
    input  logic                                  tcn_update_pointer,
    output logic                                  mem_wr_en,
    output logic [ADDR_SIZE-1:0]                  mem_wr_addr,
    output logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] mem_wr_data,
    output logic                                  out_valid,
    output logic [31:0]                           out_addr,
    output logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] out_data,
    input  logic                                  out_ready,
    output logic                                  stall,
    output logic                                  overflow,
    output logic [$clog2(FIFO_DEPTH):0]           level,
    input  logic                                  clear_overflow
);

    localparam int W   = N_DIM_ARRAY * ACT_DATA_WIDTH;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int AW1 = ADDR_SIZE + 1;

    logic                 sel_en_s;
    logic [ADDR_SIZE-1:0] sel_addr_s;
    logic [W-1:0]         sel_data_s;

    logic [ADDR_SIZE-1:0] ptr_q, ptr_d;
    logic [ADDR_SIZE-1:0] off_q, off_d;
    logic [AW1-1:0]       sum_s;
    logic [AW1-1:0]       ring_s;
    logic [ADDR_SIZE-1:0] enc_addr_s;

    logic                 mem_wr_en_q;
    logic [ADDR_SIZE-1:0] mem_wr_addr_q;
    logic [W-1:0]         mem_wr_data_q;

    logic [ADDR_SIZE-1:0] q_addr_q [FIFO_DEPTH];
    logic [W-1:0]         q_data_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 full_s, pop_s, push_s, drop_s;

    // Source selection: the unselected source has no effect at all.
    always_comb begin
        if (sel_nl) begin
            sel_en_s   = wr_en_nl;
            sel_addr_s = wr_addr_nl;
            sel_data_s = wr_data_nl;
        end else begin
            sel_en_s   = wr_en_cu;
            sel_addr_s = wr_addr_cu;
            sel_data_s = wr_data_cu;
        end
    end

    // Ring pointer and its offset advance together so off always equals ptr*block_size.
    always_comb begin
        ptr_d = ptr_q;
        off_d = off_q;
        if (tcn_active && tcn_update_pointer) begin
            if (({1'b0, ptr_q} + AW1'(1)) >= {1'b0, tcn_total_blocks}) begin
                ptr_d = {ADDR_SIZE{1'b0}};
                off_d = {ADDR_SIZE{1'b0}};
            end else begin
                ptr_d = ptr_q + ADDR_SIZE'(1);
                off_d = off_q + tcn_block_size;
            end
        end else begin
            ptr_d = ptr_q;
            off_d = off_q;
        end
    end

    // Address encoding uses the offset registered before any same-cycle pointer update.
    always_comb begin
        sum_s  = {1'b0, sel_addr_s} + {1'b0, off_q};
        ring_s = {1'b0, tcn_total_blocks} * {1'b0, tcn_block_size};
        if (!tcn_active) begin
            enc_addr_s = sel_addr_s;
        end else if (sum_s >= ring_s) begin
            enc_addr_s = ADDR_SIZE'(sum_s - ring_s);
        end else begin
            enc_addr_s = ADDR_SIZE'(sum_s);
        end
    end

    // Queue control: a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        full_s     = (level_q == LW'(FIFO_DEPTH));
        pop_s      = (level_q != {LW{1'b0}}) && out_ready;
        push_s     = sel_en_s && (!full_s || pop_s);
        drop_s     = sel_en_s && full_s && !pop_s;
        wr_ptr_d   = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Ring pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= {ADDR_SIZE{1'b0}};
            off_q <= {ADDR_SIZE{1'b0}};
        end else begin
            ptr_q <= ptr_d;
            off_q <= off_d;
        end
    end

    // Activation-memory write port; address and data hold when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= {ADDR_SIZE{1'b0}};
            mem_wr_data_q <= {W{1'b0}};
        end else begin
            mem_wr_en_q <= sel_en_s;
            if (sel_en_s) begin
                mem_wr_addr_q <= enc_addr_s;
                mem_wr_data_q <= sel_data_s;
            end
        end
    end

    // Output queue storage and bookkeeping; storage is cleared so the idle head reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_addr_q[i] <= {ADDR_SIZE{1'b0}};
                q_data_q[i] <= {W{1'b0}};
            end
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            level_q    <= {LW{1'b0}};
            overflow_q <= 1'b0;
        end else begin
            if (push_s) begin
                q_addr_q[wr_ptr_q] <= enc_addr_s;
                q_data_q[wr_ptr_q] <= sel_data_s;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign out_valid   = (level_q != {LW{1'b0}});
    assign out_addr    = 32'(q_addr_q[rd_ptr_q]);
    assign out_data    = q_data_q[rd_ptr_q];
    assign level       = level_q;
    assign stall       = (level_q >= LW'(FIFO_DEPTH - 1));
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_output_writeback_unit.sv
// Self-checking bench for output_writeback_unit: directed scenarios plus randomized
// traffic checked against a queue-based behavioural model.
module tb_output_writeback_unit;

    localparam int AS    = 16;
    localparam int W     = 64;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          sel_nl;
    logic          wr_en_cu, wr_en_nl;
    logic [AS-1:0] wr_addr_cu, wr_addr_nl;
    logic [W-1:0]  wr_data_cu, wr_data_nl;
    logic          tcn_active;
    logic [AS-1:0] tcn_block_size, tcn_total_blocks;
    logic          tcn_update_pointer;
    logic          mem_wr_en;
    logic [AS-1:0] mem_wr_addr;
    logic [W-1:0]  mem_wr_data;
    logic          out_valid;
    logic [31:0]   out_addr;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          stall;
    logic          overflow;
    logic [LW-1:0] level;
    logic          clear_overflow;

    always #5 clk = ~clk;

    output_writeback_unit #(
        .N_DIM_ARRAY(8), .ACT_DATA_WIDTH(8), .ADDR_SIZE(AS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .sel_nl(sel_nl),
        .wr_en_cu(wr_en_cu), .wr_addr_cu(wr_addr_cu), .wr_data_cu(wr_data_cu),
        .wr_en_nl(wr_en_nl), .wr_addr_nl(wr_addr_nl), .wr_data_nl(wr_data_nl),
        .tcn_active(tcn_active), .tcn_block_size(tcn_block_size),
        .tcn_total_blocks(tcn_total_blocks), .tcn_update_pointer(tcn_update_pointer),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
        .out_ready(out_ready), .stall(stall), .overflow(overflow), .level(level),
        .clear_overflow(clear_overflow)
    );

    typedef struct packed {
        logic [31:0]  a;
        logic [W-1:0] d;
    } ent_t;

    ent_t          mq[$];
    int            m_ptr;
    bit            m_over;
    bit            m_men;
    logic [AS-1:0] m_maddr;
    logic [W-1:0]  m_mdata;
    int            pass_cnt = 0;
    int            total_cnt = 0;

    // Reference: ring offset is ptr*block, encoding is modulo the ring size.
    task automatic model_step();
        bit           en, dropped;
        int           a, e;
        logic [W-1:0] d;
        en      = sel_nl ? wr_en_nl : wr_en_cu;
        a       = sel_nl ? int'(wr_addr_nl) : int'(wr_addr_cu);
        d       = sel_nl ? wr_data_nl : wr_data_cu;
        dropped = 1'b0;
        if (tcn_active)
            e = (a + m_ptr * int'(tcn_block_size)) % (int'(tcn_total_blocks) * int'(tcn_block_size));
        else
            e = a;
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (en) begin
            m_men   = 1'b1;
            m_maddr = AS'(e);
            m_mdata = d;
            if (mq.size() < DEPTH) mq.push_back({32'(e), d});
            else begin
                m_over  = 1'b1;
                dropped = 1'b1;
            end
        end else begin
            m_men = 1'b0;
        end
        if (!dropped && clear_overflow) m_over = 1'b0;
        if (tcn_active && tcn_update_pointer) m_ptr = (m_ptr + 1) % int'(tcn_total_blocks);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sel_nl = 1'b0; wr_en_cu = 1'b0; wr_en_nl = 1'b0;
        wr_addr_cu = 16'h0000; wr_addr_nl = 16'h0000;
        wr_data_cu = 64'h0; wr_data_nl = 64'h0;
        tcn_update_pointer = 1'b0; clear_overflow = 1'b0;
    endtask

    task automatic model_clear();
        mq.delete();
        m_ptr = 0; m_over = 1'b0; m_men = 1'b0; m_maddr = 16'h0000; m_mdata = 64'h0;
    endtask

    task automatic cu_write(input logic [AS-1:0] a, input logic [W-1:0] d);
        wr_en_cu = 1'b1; wr_addr_cu = a; wr_data_cu = d;
        step();
        wr_en_cu = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        model_clear();
        #1;
        total_cnt++;
        if ({mem_wr_en, out_valid, stall, overflow, level} !== 7'b0) begin
            $display("FAIL reset_flags got %b want 0", {mem_wr_en, out_valid, stall, overflow, level});
        end else pass_cnt++;
        total_cnt++;
        if ({mem_wr_addr, mem_wr_data, out_addr, out_data} !== 176'h0) begin
            $display("FAIL reset_buses got %h %h %h %h want 0", mem_wr_addr, mem_wr_data, out_addr, out_data);
        end else pass_cnt++;
        wr_en_cu = 1'b1; wr_addr_cu = 16'h0055; wr_data_cu = 64'hDEAD;
        @(posedge clk); #1;
        total_cnt++;
        if ({mem_wr_en, level} !== 4'b0) begin
            $display("FAIL reset_discard got en=%b level=%0d want 0", mem_wr_en, level);
        end else pass_cnt++;
        idle();
        reset = 1'b1;
        step();
    endtask

    task automatic test_bypass();
        idle();
        cu_write(16'h0010, 64'h0102030405060708);
        total_cnt++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 16'h0010, 64'h0102030405060708}) begin
            $display("FAIL bypass_mem got %b %h %h want 1 0010 0102030405060708", mem_wr_en, mem_wr_addr, mem_wr_data);
        end else pass_cnt++;
        total_cnt++;
        if ({out_valid, out_addr, out_data} !== {1'b1, 32'h00000010, 64'h0102030405060708}) begin
            $display("FAIL bypass_out got %b %h %h want 1 00000010 0102030405060708", out_valid, out_addr, out_data);
        end else pass_cnt++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total_cnt++;
        if ({out_valid, mem_wr_en, mem_wr_addr} !== {2'b00, 16'h0010}) begin
            $display("FAIL bypass_drain got v=%b en=%b addr=%h want 0 0 0010", out_valid, mem_wr_en, mem_wr_addr);
        end else pass_cnt++;
    endtask

    task automatic test_wrap();
        idle();
        tcn_active = 1'b1; tcn_block_size = 16'd4; tcn_total_blocks = 16'd3;
        out_ready = 1'b1;
        repeat (2) begin
            tcn_update_pointer = 1'b1; step();
            tcn_update_pointer = 1'b0; step();
        end
        cu_write(16'd6, 64'hA1);
        total_cnt++;
        if ({mem_wr_en, mem_wr_addr} !== {1'b1, 16'd2}) begin
            $display("FAIL wrap_addr got en=%b addr=%0d want 1 2", mem_wr_en, mem_wr_addr);
        end else pass_cnt++;
        // third pulse coincides with a write: pre-update offset 8 still applies
        tcn_update_pointer = 1'b1;
        cu_write(16'd6, 64'hA2);
        tcn_update_pointer = 1'b0;
        total_cnt++;
        if (mem_wr_addr !== 16'd2 || m_maddr !== 16'd2) begin
            $display("FAIL wrap_same_cycle got %0d want 2", mem_wr_addr);
        end else pass_cnt++;
        cu_write(16'd6, 64'hA3);
        total_cnt++;
        if (mem_wr_addr !== 16'd6 || out_addr !== 32'd6) begin
            $display("FAIL wrap_ptr0 got mem=%0d out=%0d want 6 6", mem_wr_addr, out_addr);
        end else pass_cnt++;
        step();
        tcn_active = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n_mem;
        idle();
        out_ready = 1'b0;
        n_mem = 0;
        for (int i = 0; i < 5; i++) begin
            cu_write(16'h0100 + 16'(i), {32'hB0B0_0000 + 32'(i), 32'h1234_0000 + 32'(i)});
            if (mem_wr_en === 1'b1) n_mem++;
            if (i == 1) begin
                total_cnt++;
                if ({stall, level} !== {1'b0, 3'd2}) begin
                    $display("FAIL bp_no_stall got stall=%b level=%0d want 0 2", stall, level);
                end else pass_cnt++;
            end
            if (i == 2) begin
                total_cnt++;
                if ({stall, level} !== {1'b1, 3'd3}) begin
                    $display("FAIL bp_stall got stall=%b level=%0d want 1 3", stall, level);
                end else pass_cnt++;
            end
        end
        total_cnt++;
        if ({level, overflow, stall} !== {3'd4, 2'b11} || n_mem != 5) begin
            $display("FAIL bp_full got level=%0d ovf=%b stall=%b memw=%0d want 4 1 1 5", level, overflow, stall, n_mem);
        end else pass_cnt++;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if ({out_valid, out_addr} !== {1'b1, 32'h0100 + 32'(k)}) begin
                $display("FAIL bp_order[%0d] got v=%b addr=%h want 1 %h", k, out_valid, out_addr, 32'h0100 + 32'(k));
            end else pass_cnt++;
            step();
        end
        out_ready = 1'b0;
        total_cnt++;
        if ({out_valid, overflow} !== 2'b01) begin
            $display("FAIL bp_fifth_absent got v=%b ovf=%b want 0 1", out_valid, overflow);
        end else pass_cnt++;
        clear_overflow = 1'b1; step(); clear_overflow = 1'b0;
        total_cnt++;
        if (overflow !== 1'b0) begin
            $display("FAIL bp_clear got %b want 0", overflow);
        end else pass_cnt++;
    endtask

    task automatic test_full_pushpop();
        idle();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) cu_write(16'h0200 + 16'(i), 64'(i + 10));
        out_ready = 1'b1;
        cu_write(16'h0204, 64'd14);
        total_cnt++;
        if ({level, overflow, out_addr} !== {3'd4, 1'b0, 32'h0201}) begin
            $display("FAIL fpp_level got level=%0d ovf=%b head=%h want 4 0 0201", level, overflow, out_addr);
        end else pass_cnt++;
        for (int k = 1; k < 5; k++) begin
            total_cnt++;
            if ({out_valid, out_addr, out_data} !== {1'b1, 32'h0200 + 32'(k), 64'(k + 10)}) begin
                $display("FAIL fpp_order[%0d] got v=%b addr=%h data=%h", k, out_valid, out_addr, out_data);
            end else pass_cnt++;
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_select();
        idle();
        out_ready = 1'b1;
        sel_nl = 1'b1;
        wr_en_cu = 1'b1; wr_addr_cu = 16'h0AAA; wr_data_cu = 64'hCCCC_CCCC_CCCC_CCCC;
        wr_en_nl = 1'b1; wr_addr_nl = 16'h0555; wr_data_nl = 64'h5555_6666_7777_8888;
        step();
        total_cnt++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data, out_addr} !==
            {1'b1, 16'h0555, 64'h5555_6666_7777_8888, 32'h0555}) begin
            $display("FAIL sel_nl got %b %h %h %h want 1 0555 5555666677778888 0555", mem_wr_en, mem_wr_addr, mem_wr_data, out_addr);
        end else pass_cnt++;
        wr_en_nl = 1'b0;
        step();
        total_cnt++;
        if ({mem_wr_en, out_valid, mem_wr_addr} !== {2'b00, 16'h0555}) begin
            $display("FAIL sel_cu_ignored got en=%b v=%b addr=%h want 0 0 0555", mem_wr_en, out_valid, mem_wr_addr);
        end else pass_cnt++;
        idle();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        idle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cu_write(16'h0300 + 16'(i), 64'(i));
        reset = 1'b0;
        model_clear();
        #1;
        total_cnt++;
        if ({out_valid, level, stall} !== 5'b0) begin
            $display("FAIL midrst_clear got v=%b level=%0d stall=%b want 0", out_valid, level, stall);
        end else pass_cnt++;
        reset = 1'b1;
        step();
        cu_write(16'h0333, 64'hFEED_FACE_0000_0333);
        total_cnt++;
        if ({out_valid, level, out_addr, out_data} !== {1'b1, 3'd1, 32'h0333, 64'hFEED_FACE_0000_0333}) begin
            $display("FAIL midrst_first got v=%b level=%0d addr=%h data=%h", out_valid, level, out_addr, out_data);
        end else pass_cnt++;
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_random();
        int ring;
        for (int seg = 0; seg < 4; seg++) begin
            idle();
            reset = 1'b0; model_clear(); #1; reset = 1'b1;
            tcn_active       = 1'(seg % 2);
            tcn_block_size   = 16'($urandom_range(5, 1));
            tcn_total_blocks = 16'($urandom_range(4, 1));
            ring = int'(tcn_block_size) * int'(tcn_total_blocks);
            for (int c = 0; c < 100; c++) begin
                sel_nl     = 1'($urandom_range(1, 0));
                wr_en_cu   = ($urandom_range(3, 0) != 0);
                wr_en_nl   = ($urandom_range(3, 0) != 0);
                wr_addr_cu = tcn_active ? 16'($urandom_range(ring - 1, 0)) : 16'($urandom);
                wr_addr_nl = tcn_active ? 16'($urandom_range(ring - 1, 0)) : 16'($urandom);
                wr_data_cu = {$urandom, $urandom};
                wr_data_nl = {$urandom, $urandom};
                out_ready  = ($urandom_range(2, 0) == 0);
                tcn_update_pointer = ($urandom_range(4, 0) == 0);
                clear_overflow     = ($urandom_range(9, 0) == 0);
                step();
                total_cnt++;
                if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {m_men, m_maddr, m_mdata}) begin
                    $display("FAIL rnd_mem[%0d.%0d] got %b %h %h want %b %h %h", seg, c,
                             mem_wr_en, mem_wr_addr, mem_wr_data, m_men, m_maddr, m_mdata);
                end else pass_cnt++;
                total_cnt++;
                if ({out_valid, level, stall, overflow} !==
                    {mq.size() > 0, LW'(mq.size()), mq.size() >= DEPTH - 1, m_over}) begin
                    $display("FAIL rnd_ctl[%0d.%0d] got v=%b lvl=%0d st=%b ovf=%b want lvl=%0d ovf=%b",
                             seg, c, out_valid, level, stall, overflow, mq.size(), m_over);
                end else pass_cnt++;
                if (mq.size() > 0) begin
                    total_cnt++;
                    if ({out_addr, out_data} !== {mq[0].a, mq[0].d}) begin
                        $display("FAIL rnd_head[%0d.%0d] got %h %h want %h %h", seg, c,
                                 out_addr, out_data, mq[0].a, mq[0].d);
                    end else pass_cnt++;
                end
            end
        end
        idle();
        tcn_active = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        tcn_active = 1'b0; tcn_block_size = 16'd0; tcn_total_blocks = 16'd0;
        out_ready = 1'b0;
        test_reset();
        test_bypass();
        test_wrap();
        test_backpressure();
        test_full_pushpop();
        test_select();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/output_writeback_unit.md
OUTPUT_WRITEBACK_UNIT -- requirements
Module: output_writeback_unit

Interface
REQ-001 SHALL provide parameter N_DIM_ARRAY, default 8, lanes per output word.
REQ-002 SHALL provide parameter ACT_DATA_WIDTH, default 8, bits per lane; word width W = N_DIM_ARRAY*ACT_DATA_WIDTH.
REQ-003 SHALL provide parameter ADDR_SIZE, default 16, activation-memory address width.
REQ-004 SHALL provide parameter FIFO_DEPTH, default 4, external-output queue entries (power of two, >=2).
REQ-005 SHALL have ports:
- clk  in  1  clock, single domain.
- reset  in  1  asynchronous, active-low reset.
- sel_nl  in  1  1 selects the nonlinear-block source, 0 selects the control-unit source.
- wr_en_cu / wr_addr_cu / wr_data_cu  in  1 / ADDR_SIZE / W  control-unit write.
- wr_en_nl / wr_addr_nl / wr_data_nl  in  1 / ADDR_SIZE / W  nonlinear-block write.
- tcn_active  in  1  enables circular frame-by-frame addressing.
- tcn_block_size  in  ADDR_SIZE  words per block.
- tcn_total_blocks  in  ADDR_SIZE  blocks in the ring.
- tcn_update_pointer  in  1  one-cycle pulse that advances the ring pointer.
- mem_wr_en / mem_wr_addr / mem_wr_data  out  1 / ADDR_SIZE / W  activation-memory write.
- out_valid / out_addr / out_data  out  1 / 32 / W  external output stream.
- out_ready  in  1  external sink accepts the head entry.
- stall  out  1  queue almost full.
- overflow  out  1  sticky drop flag.
- level  out  clog2(FIFO_DEPTH)+1  queue occupancy.
- clear_overflow  in  1  clears the overflow flag.

Function
REQ-006 SHALL select the write triple {en, addr, data} from the nl inputs when sel_nl=1, otherwise from the cu inputs; the unselected source SHALL be ignored.
REQ-007 SHALL keep a ring pointer ptr in the range 0..tcn_total_blocks-1 and a registered offset off = ptr*tcn_block_size, maintained incrementally by adding tcn_block_size and wrapping to 0, with no multiplier.
REQ-008 On a tcn_update_pointer pulse with tcn_active=1, ptr SHALL advance by 1; from tcn_total_blocks-1 it SHALL wrap to 0, and off SHALL return to 0.
REQ-009 With tcn_active=0, ptr and off SHALL hold, and the encoded address SHALL equal the raw address.
REQ-010 With tcn_active=1, the encoded address SHALL be e = addr + off; when e >= tcn_total_blocks*tcn_block_size, the ring size SHALL be subtracted once; arithmetic SHALL be ADDR_SIZE+1 bits wide.
REQ-011 A pointer update in the same cycle as a write SHALL encode that write with the pre-update offset.
REQ-012 Each selected write SHALL produce a registered memory write one cycle later:
- mem_wr_en = 1.
- mem_wr_addr = encoded address.
- mem_wr_data = selected data.
- With no write, mem_wr_en = 0 and mem_wr_addr/mem_wr_data hold.
REQ-013 Each selected write SHALL push {zero-extended encoded address, data} into the queue in the same cycle the memory write is registered.
REQ-014 out_valid SHALL be 1 whenever level>0; out_addr and out_data SHALL show the head entry; a pop occurs when out_valid & out_ready.
REQ-015 Queue order SHALL be first-in first-out; a push into an empty queue SHALL appear on out_valid on the next cycle, with no bypass.
REQ-016 A push while the queue is full and no pop occurs SHALL drop the entry and set overflow; the memory write SHALL still occur.
REQ-017 A push and a pop in the same cycle SHALL both succeed, including when the queue is full, and level SHALL be unchanged.
REQ-018 stall SHALL equal (level >= FIFO_DEPTH-1), combinationally from registered level.
REQ-019 overflow SHALL remain set until clear_overflow=1; if a drop and clear_overflow occur in the same cycle, overflow SHALL be set.
REQ-020 Queue pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-021 When reset=0, the block SHALL immediately clear ptr, off, level, queue pointers, mem_wr_en, out_valid, stall, overflow, mem_wr_addr, mem_wr_data, out_addr and out_data to 0.
REQ-022 Writes presented while reset=0 SHALL be discarded.
REQ-023 A reset asserted mid-stream SHALL discard queued entries, and after release the first push SHALL appear as the head entry.

Verification
REQ-024 Bench SHALL cover bypass: tcn_active=0, sel_nl=0, cu write addr 0x0010, data 0x0102030405060708 -> next cycle mem_wr_en=1, mem_wr_addr=0x0010; out_valid=1, out_addr=0x00000010.
REQ-025 Bench SHALL cover wrap: block_size=4, total_blocks=3, two update pulses (ptr=2, off=8), then write addr 6 -> mem_wr_addr=2; a third pulse sets ptr=0.
REQ-026 Bench SHALL cover backpressure: out_ready=0, 5 writes with FIFO_DEPTH=4 -> stall=1 at level 3, level=4, overflow=1, 5 memory writes issued, fifth entry absent from the stream.
REQ-027 Bench SHALL cover full push/pop: level=4, out_ready=1 plus a write in the same cycle -> level stays 4, overflow stays 0, output order preserved.
REQ-028 Bench SHALL cover source select: sel_nl=1 with both wr_en_cu and wr_en_nl high -> only nl address and data written.
REQ-029 Bench SHALL cover reset: reset pulsed low with level=3 -> out_valid=0 and level=0 immediately, and the next write after release reaches out_data.
